// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO peripheral: button synchronizer + debouncer with press
// event latching (sticky pending flag, 16-bit press counter), CPU-writable
// LED bank, and a registered level interrupt on pending presses.
module gpio_mmio #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter int LED_W           = 6,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             button_in,
    input  logic             bus_sel,
    input  logic             bus_we,
    input  logic             bus_re,
    input  logic [3:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             irq,
    output logic [LED_W-1:0] led
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_LED    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_IRQEN  = 2'd3;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [15:0]      press_cnt_q, press_cnt_d;
    logic             irq_en_q, irq_en_d;
    logic [LED_W-1:0] led_out_q, led_out_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic             pressed_raw;
    logic             press_evt;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       reg_sel;
    logic             unused_bits;

    assign wr_en   = bus_sel & bus_we;
    assign rd_en   = bus_sel & bus_re;
    assign reg_sel = bus_addr[3:2];

    // Byte-lane bits of the address and write-data bits beyond the registers are ignored.
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:LED_W]};

    // Two-flop synchronizer and debouncer: accept a new level only after it
    // has been seen for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        sync1_d     = button_in;
        sync2_d     = sync1_q;
        pressed_raw = ~sync2_q;
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        if (pressed_raw == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = pressed_raw;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_evt = stable_d & ~stable_q;
    end

    // Register writes; a press event on the same edge overrides the clear.
    always_comb begin
        led_out_d   = led_out_q;
        irq_en_d    = irq_en_q;
        pending_d   = pending_q;
        press_cnt_d = press_cnt_q;
        if (wr_en) begin
            case (reg_sel)
                ADDR_LED:    led_out_d = bus_wdata[LED_W-1:0];
                ADDR_STATUS: if (bus_wdata[1]) pending_d = 1'b0;
                ADDR_COUNT:  press_cnt_d = '0;
                ADDR_IRQEN:  irq_en_d = bus_wdata[0];
                default:     ;
            endcase
        end
        if (press_evt) begin
            pending_d   = 1'b1;
            press_cnt_d = press_cnt_d + 16'd1;
        end
    end

    // Registered read data from pre-write register values, and the interrupt level.
    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (reg_sel)
                ADDR_LED:    rdata_d = {{(32-LED_W){1'b0}}, led_out_q};
                ADDR_STATUS: rdata_d = {30'b0, pending_q, stable_q};
                ADDR_COUNT:  rdata_d = {16'b0, press_cnt_q};
                ADDR_IRQEN:  rdata_d = {31'b0, irq_en_q};
                default:     rdata_d = '0;
            endcase
        end
        irq_d = pending_q & irq_en_q;
    end

    // State registers with synchronous reset; synchronizer resets to released.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            stable_q    <= 1'b0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            press_cnt_q <= '0;
            irq_en_q    <= 1'b0;
            led_out_q   <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            press_cnt_q <= press_cnt_d;
            irq_en_q    <= irq_en_d;
            led_out_q   <= led_out_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    // LED pin polarity applied combinationally from the register.
    always_comb begin
        if (LED_ACTIVE_LOW != 0) led = ~led_out_q;
        else                     led = led_out_q;
    end

    assign bus_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio: read results go through an expected-value
// queue and are compared one cycle after the read strobe.
module tb_gpio_mmio;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        button_in;
    logic        bus_sel;
    logic        bus_we;
    logic        bus_re;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;
    logic [5:0]  led;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    gpio_mmio #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W(20),
        .LED_W(6),
        .LED_ACTIVE_LOW(1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .button_in(button_in),
        .bus_sel(bus_sel),
        .bus_we(bus_we),
        .bus_re(bus_re),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .irq(irq),
        .led(led)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge sys_clk);
        @(negedge sys_clk);
        bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] expv, input string tag);
        logic [31:0] e;
        string t;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        bus_sel = 1'b1; bus_re = 1'b1; bus_addr = a;
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, bus_rdata, e);
        @(negedge sys_clk);
        bus_sel = 1'b0; bus_re = 1'b0;
    endtask

    // Full press/release cycle, long enough for both debounced transitions.
    task automatic press_release();
        button_in = 1'b0;
        idle(25);
        button_in = 1'b1;
        idle(25);
    endtask

    initial begin
        sys_rst = 1'b1; button_in = 1'b1;
        bus_sel = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
        bus_addr = '0; bus_wdata = '0;
        idle(5);
        check("rst_led", {26'b0, led}, 32'h3F);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        sys_rst = 1'b0;
        rd(4'h0, 32'h0, "rst_rd_led");
        rd(4'h4, 32'h0, "rst_rd_status");
        rd(4'h8, 32'h0, "rst_rd_count");
        rd(4'hC, 32'h0, "rst_rd_irqen");

        // Glitch shorter than the debounce window
        button_in = 1'b0;
        idle(10);
        button_in = 1'b1;
        idle(25);
        rd(4'h4, 32'h0, "glitch_status");
        rd(4'h8, 32'h0, "glitch_count");

        // Press with interrupt enabled: stable rises on edge 18
        wr(4'hC, 32'h1);
        rd(4'hC, 32'h1, "irqen_rd");
        button_in = 1'b0;
        idle(17);
        rd(4'h4, 32'h0, "press_edge17_status");
        check("press_irq_before", {31'b0, irq}, 32'h0);
        rd(4'h4, 32'h3, "press_edge18_status");
        check("press_irq", {31'b0, irq}, 32'h1);
        rd(4'h8, 32'h1, "press_count");
        idle(80);

        // Release: no event, stable falls on edge 18
        button_in = 1'b1;
        idle(17);
        rd(4'h4, 32'h3, "release_edge17_status");
        rd(4'h4, 32'h2, "release_edge18_status");
        rd(4'h8, 32'h1, "release_count");
        wr(4'h4, 32'h2);
        rd(4'h4, 32'h0, "clear_status");
        check("clear_irq", {31'b0, irq}, 32'h0);

        // LED register and active-low pins
        wr(4'h0, 32'h15);
        check("led_0x15", {26'b0, led}, 32'h2A);
        rd(4'h0, 32'h15, "led_rd_0x15");
        wr(4'h0, 32'hFFFF_FFC0);
        check("led_upper", {26'b0, led}, 32'h3F);
        rd(4'h0, 32'h0, "led_rd_upper");

        // Pending clear collides with a press event: set wins
        button_in = 1'b0;
        idle(17);
        wr(4'h4, 32'h2);
        rd(4'h4, 32'h3, "coll_pending");
        rd(4'h8, 32'h2, "coll_count_before");
        button_in = 1'b1;
        idle(25);

        // PRESS_COUNT write collides with a press event: count becomes 1
        button_in = 1'b0;
        idle(17);
        wr(4'h8, 32'h0);
        rd(4'h8, 32'h1, "coll_count");
        button_in = 1'b1;
        idle(25);

        // Build PRESS_COUNT=3, then reset while button held
        press_release();
        button_in = 1'b0;
        idle(25);
        rd(4'h8, 32'h3, "count_three");
        sys_rst = 1'b1;
        idle(3);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check("midrst_led", {26'b0, led}, 32'h3F);
        sys_rst = 1'b0;
        rd(4'h8, 32'h0, "midrst_count_zero");
        idle(16);
        rd(4'h4, 32'h0, "midrst_edge17_status");
        rd(4'h4, 32'h3, "midrst_edge18_status");
        rd(4'h8, 32'h1, "midrst_count");
        button_in = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_mmio.md
Name: gpio_mmio

Overview:
Memory-mapped GPIO peripheral between the board pins and the CPU data bus. It synchronizes and debounces the raw active-low push button and latches press events as a sticky flag and a press counter. It drives the 6-bit LED bank from a CPU-writable register and raises a level interrupt on pending presses. Top instantiates it on the pin side, with the CPU's load/store path as the bus master.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a new button level (min 2)
CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1
LED_W, 6, number of LED outputs
LED_ACTIVE_LOW, 1, 1: led pin = ~LED_OUT; 0: led pin = LED_OUT

Ports:
sys_clk  in  1  single system clock; all state on rising edge
sys_rst  in  1  synchronous, active-high reset
button_in  in  1  raw asynchronous button, active-low (0 = pressed)
bus_sel  in  1  peripheral selected this cycle
bus_we  in  1  write strobe (qualified by bus_sel)
bus_re  in  1  read strobe (qualified by bus_sel)
bus_addr  in  4  byte offset; only [3:2] decoded
bus_wdata  in  32  write data
bus_rdata  out  32  registered read data
irq  out  1  registered interrupt, level
led  out  LED_W  LED pins

Behaviour:
- Reset values: LED_OUT=0 (led=all 1s when LED_ACTIVE_LOW), sync flops=1 (released), stable level=0, debounce count=0, pending=0, PRESS_COUNT=0, IRQ_EN=0, bus_rdata=0, irq=0.
- Synchronizer: two flops on button_in; pressed_raw = ~sync2.
- Debouncer: if pressed_raw==stable, count<=0. Otherwise count++. On the edge where count==DEBOUNCE_CYCLES-1, stable<=pressed_raw and count<=0. Any bounce back resets count.
- Latency: a pin edge held steady changes stable on the (2+DEBOUNCE_CYCLES)th rising edge after it.
- Press event: on the edge where stable goes 0->1, pending<=1 and PRESS_COUNT<=PRESS_COUNT+1 (16-bit, wraps 0xFFFF->0). A release (1->0) generates no event.
- Register map (word offsets):
  0x0 LED_OUT RW [LED_W-1:0]. Upper bits read 0.
  0x4 STATUS: read {30'b0, pending, stable}. Writing with wdata[1]=1 clears pending.
  0x8 PRESS_COUNT: RO [15:0]. Any write clears it to 0.
  0xC IRQ_EN RW [0].
- Writes take effect on the edge where bus_sel&bus_we.
- Reads: bus_rdata is registered and holds the addressed value on the cycle after bus_sel&bus_re; otherwise 0. Read-during-write to the same register returns the pre-write value.
- bus_we and bus_re together: the write is performed, and the read returns the pre-write value.
- Reads have no side effects.
- irq <= pending & IRQ_EN (one-cycle lag from either term).
- Simultaneous events:
  - Pending clear on the same edge as a press event: pending=1 (set wins).
  - PRESS_COUNT write on the same edge as a press event: PRESS_COUNT=1.
- Reset mid-press: all state returns to reset values. If the button is still held after reset deasserts, it is debounced as a new press (pending=1, count=1).
- led = LED_ACTIVE_LOW ? ~LED_OUT : LED_OUT, combinational from the register.

Test Plan:
- Reset with sys_rst=1 for 5 cycles, button_in=1 -> led=6'b111111, irq=0; reads of 0x0/0x4/0x8/0xC return 0.
- Glitch: button_in=0 for 10 cycles then 1 -> STATUS reads 0, PRESS_COUNT reads 0.
- Press: button_in=0 held 100 cycles, IRQ_EN=1 -> STATUS[0] rises exactly 18 edges after the falling edge; STATUS=0x3, PRESS_COUNT=1, irq=1 one cycle later. Release -> STATUS[0] falls 18 edges later, PRESS_COUNT stays 1. Writing 0x2 to 0x4 -> STATUS=0x0, irq=0.
- LED: write 0x15 to 0x0 -> led=6'b101010 next cycle; read 0x0 returns 0x00000015. Write 0xFFFFFFC0 -> led=6'b111111, read returns 0.
- Collision: write 0x2 to 0x4 and write to 0x8, both on the stable 0->1 edge -> pending=1, PRESS_COUNT=1.
- Reset mid-press: assert sys_rst while button held and PRESS_COUNT=3; release reset with button still held -> PRESS_COUNT=1 and pending=1 after 18 edges.
